stream_ready_stall: RTL
=======================

# stream_ready_stall

Sink-side counterpart of the valid-delaying stream stage: it throttles the **ready** side of a valid/ready stream instead of the valid side. It captures each incoming beat into a one-entry buffer and presents it downstream. After each beat leaves, it holds upstream `ready_o` low for a fixed or pseudo-random number of cycles. It sits in front of receivers in testbenches and in verification-only fabric paths, to stress producers with realistic backpressure.

## Interface
- `StallRandom`, 0: 1 = stall length taken from an internal LFSR; 0 = `FixedDelay`.
- `FixedDelay`, 1: stall length in cycles when `StallRandom`=0. Legal range 0..15; any other value is an elaboration error.
- `payload_t`, logic: beat type.
- `Seed`, 16'h0000: LFSR reset value. A value of 0 is replaced by 16'hACE1.

Ports:
- `clk_i` in 1: clock, all logic on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `payload_i` in `$bits(payload_t)`: upstream beat.
- `valid_i` in 1: upstream valid.
- `ready_o` out 1: upstream ready.
- `payload_o` out `$bits(payload_t)`: buffered beat.
- `valid_o` out 1: downstream valid.
- `ready_i` in 1: downstream ready.

## Operation
- **Registers:**
  - state (Accept, Hold, Stall)
  - `buf_q` (payload_t)
  - `cnt_q` (4 bit)
  - `lfsr_q` (16 bit)
- **Outputs:**
  - `ready_o` = (state==Accept) && !`rst_i`.
  - `valid_o` = (state==Hold).
  - `payload_o` = `buf_q` at all times.
- **Accept:**
  - On `valid_i`&&`ready_o`, capture `buf_q` <= `payload_i` and go to Hold.
  - Otherwise stay in Accept.
- **Hold:**
  - On `ready_i`, the beat is consumed. Load `cnt_q` <= d, where d = `FixedDelay` or `lfsr_q[3:0]`.
  - If d==0, go to Accept; else go to Stall.
  - Without `ready_i`, stay in Hold. `buf_q` and `valid_o` stay stable; the valid is never retracted.
- **Stall:**
  - `cnt_q` decrements each cycle.
  - When `cnt_q`==1, go to Accept. Stall therefore lasts exactly d cycles.
- **LFSR:**
  - Fibonacci, taps 16/14/13/11, shift-left, feedback into bit 0.
  - Advances only on the downstream handshake (Hold && `ready_i`). It is idle otherwise.
  - The d used at a handshake is the pre-advance `lfsr_q[3:0]`.
- When `StallRandom`=0, the LFSR is not instantiated.
- The buffer is always present, including when `FixedDelay`=0. There is no pass-through mode and no combinational path from input to output.
- **Reset:** state <= Accept, `buf_q` <= '0, `cnt_q` <= 0, `lfsr_q` <= Seed (or 16'hACE1).
  - While `rst_i` is high: `ready_o`=0, `valid_o`=0, `payload_o`='0.
- **Reset mid-operation:** a buffered beat is dropped silently and any stall in progress is cancelled.
  - The first cycle after `rst_i` falls has `ready_o`=1.

## Timing
- Upstream accept in cycle t gives `valid_o`=1 in cycle t+1.
- Downstream handshake in cycle h gives `ready_o`=1 again in cycle h+1+d.
- Peak throughput is 1 beat per 2 cycles (d=0, `ready_i` held high).
- `ready_o` does not depend on `valid_i` in the same cycle.
- `valid_o` does not depend on `ready_i` in the same cycle.
- Both outputs come straight from registers or state decode, plus the `rst_i` gate on `ready_o`.
- At most one beat is in flight. An upstream and a downstream handshake never occur in the same cycle.
- `cnt_q` never wraps: it is loaded only at a downstream handshake and is decremented only in Stall, where it is ≥1.
- `valid_i` dropping before acceptance is tolerated (no protocol check).

## Test plan
- **Fixed delay:** `FixedDelay`=3, `ready_i`=1, `valid_i`=1 continuously with payloads 0xA0,0xA1,….
  - Required: accepts at cycles 0,5,10.
  - `valid_o` high at cycles 1,6,11 with payloads 0xA0,0xA1,0xA2.
  - `ready_o` low for exactly 3 cycles (cycles 2–4) after each downstream handshake, and also low in the Hold cycle.
- **Zero delay:** `FixedDelay`=0, continuous traffic.
  - Required: `ready_o`/`valid_o` alternate every cycle; 8 beats complete in 16 cycles, in order, with no loss.
- **Downstream backpressure:** `ready_i`=0 for 6 cycles after the beat 0x5A is buffered.
  - Required: `valid_o` stays 1 and `payload_o` stays 0x5A; `ready_o` stays 0 throughout.
  - Stall starts only after `ready_i` rises.
- **Random stall:** `StallRandom`=1, Seed=16'h0001, 20 beats.
  - Required: each stall length equals the low nibble of the golden-model LFSR sequence, advanced once per handshake.
  - A zero nibble yields an immediate return to Accept.
- **Reset mid-operation:** assert `rst_i` with 0x77 in Hold, then again in the middle of a Stall with `cnt_q`=2.
  - Required: during reset, `valid_o`=0, `ready_o`=0, `payload_o`=0.
  - First cycle after release: `ready_o`=1, and 0x77 is never emitted.
- **Seed zero:** `StallRandom`=1, Seed=0.
  - Required: `lfsr_q`=16'hACE1 after reset, and the first stall is 1 cycle (nibble 0x1).

Source files
------------

// File: rtl/stream_ready_stall.sv
// stream_ready_stall
//   Sink-side backpressure generator. Each upstream beat is captured into a
//   one-entry buffer and offered downstream. Once the beat leaves, upstream
//   ready is held low for a stall of d cycles. d is either the fixed value
//   FixedDelay or the low nibble of a 16-bit LFSR.
//
// Parameters
//   StallRandom : 1 = stall length from the LFSR, 0 = FixedDelay
//   FixedDelay  : stall length when StallRandom=0 (0..15)
//   payload_t   : beat type
//   Seed        : LFSR reset value (0 is replaced by 16'hACE1)
//
// Ports
//   clk_i     in  : clock, rising edge
//   rst_i     in  : synchronous active-high reset
//   payload_i in  : upstream beat
//   valid_i   in  : upstream valid
//   ready_o   out : upstream ready
//   payload_o out : buffered beat
//   valid_o   out : downstream valid
//   ready_i   in  : downstream ready
module stream_ready_stall #(
  parameter bit          StallRandom = 1'b0,
  parameter int          FixedDelay  = 1,
  parameter type         payload_t   = logic,
  parameter logic [15:0] Seed        = 16'h0000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [$bits(payload_t)-1:0] payload_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [$bits(payload_t)-1:0] payload_o,
  output logic                        valid_o,
  input  logic                        ready_i
);

  localparam int PW = $bits(payload_t);

  // Out-of-range stall lengths cannot be represented by the 4-bit counter.
  if (FixedDelay < 0 || FixedDelay > 15) begin : gen_bad_fixed_delay
    $error("stream_ready_stall: FixedDelay must be in 0..15");
  end

  typedef enum logic [1:0] {
    Accept = 2'd0,
    Hold   = 2'd1,
    Stall  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] buf_q;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    delay;
  logic          accept;
  logic          consume;

  // Outputs are pure state decode; the reset gate keeps everything quiet
  // during the reset cycle itself, before the registers have cleared.
  assign ready_o   = (state_q == Accept) && !rst_i;
  assign valid_o   = (state_q == Hold) && !rst_i;
  assign payload_o = rst_i ? '0 : buf_q;

  assign accept  = valid_i && ready_o;
  assign consume = (state_q == Hold) && ready_i && !rst_i;

  if (StallRandom) begin : gen_lfsr
    localparam logic [15:0] LfsrInit = (Seed == 16'h0000) ? 16'hACE1 : Seed;

    logic [15:0] lfsr_q;
    logic        feedback;

    // Fibonacci taps 16/14/13/11, shifted left with feedback into bit 0.
    assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Advances only on the downstream handshake, so the stall length used at
    // a handshake is the pre-advance low nibble.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        lfsr_q <= LfsrInit;
      end else if (consume) begin
        lfsr_q <= {lfsr_q[14:0], feedback};
      end
    end

    assign delay = lfsr_q[3:0];
  end else begin : gen_fixed
    assign delay = 4'(FixedDelay);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      Accept: begin
        if (accept) begin
          state_d = Hold;
        end
      end
      Hold: begin
        // Valid is never retracted: stay here until the beat is taken.
        if (ready_i) begin
          cnt_d   = delay;
          state_d = (delay == 4'd0) ? Accept : Stall;
        end
      end
      Stall: begin
        // Entered with cnt_q = d >= 1, so the stall lasts exactly d cycles
        // and the counter never wraps.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = Accept;
        end
      end
      default: begin
        state_d = Accept;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Accept;
      buf_q   <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        buf_q <= payload_i;
      end
    end
  end

endmodule
